bus_rr_scheduler: RTL

//  Central scheduler for the shared packet bus between DRVS driver-side FIFOs.

---
 rtl/bus_sched_pkg.sv | 20 ++
 rtl/rr_priority_picker.sv | 24 ++
 rtl/bus_rr_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
package bus_sched_pkg;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  localparam logic [7:0] BCAST_ID_DEF = 8'hFF;
  localparam int         MAX_W        = 256;

  function automatic logic [MAX_W-1:0] onehot(input int unsigned idx);
    return MAX_W'(1) << idx;
  endfunction

  // Destination field sits in the top id_w bits of a pckg_sz-bit packet.
  function automatic logic [MAX_W-1:0] dest_field(input logic [MAX_W-1:0] pkt,
                                                  input int unsigned pckg_sz,
                                                  input int unsigned id_w);
    return (pkt >> (pckg_sz - id_w)) & ((MAX_W'(1) << id_w) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_priority_picker #(
  parameter int N  = 8,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Scan from the farthest candidate down so the nearest one after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[LW'((int'(last) + k) % N)]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for the shared packet bus: grant, pop the head packet,
// then deliver it to one destination FIFO or broadcast it to all others.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int              PCKG_SZ  = 16,
  parameter int              DRVS     = 8,
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] BCAST_ID = ID_W'(BCAST_ID_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DRVS-1:0]         pndng,
  input  logic [DRVS*PCKG_SZ-1:0] D_pop,
  output logic [DRVS-1:0]         pop,
  output logic [DRVS-1:0]         push,
  output logic [PCKG_SZ-1:0]      D_push,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    err_drop
);

  localparam int LW = (DRVS > 1) ? $clog2(DRVS) : 1;

  state_t              state_q;
  logic [LW-1:0]       last_q;
  logic [ID_W-1:0]     grant_q;
  logic [PCKG_SZ-1:0]  pkt_q, dpush_q;
  logic [DRVS-1:0]     pop_q, push_q;
  logic                err_q;

  logic [LW-1:0]       pick_idx;
  logic                pick_vld;
  logic [PCKG_SZ-1:0]  slice [DRVS];
  logic [ID_W-1:0]     dest;
  logic [DRVS-1:0]     self_oh, dest_oh, tgt;
  logic                dest_ok, is_self, drop;

  for (genvar g = 0; g < DRVS; g++) begin : g_slice
    assign slice[g] = D_pop[g*PCKG_SZ +: PCKG_SZ];
  end

  rr_priority_picker #(.N(DRVS), .LW(LW)) u_pick (
    .req     (pndng),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // last_q always equals the granted driver once we leave IDLE.
  assign self_oh = DRVS'(onehot(32'(last_q)));
  assign dest    = ID_W'(dest_field(MAX_W'(pkt_q), PCKG_SZ, ID_W));
  assign dest_oh = DRVS'(onehot(32'(dest)));
  assign dest_ok = 32'(dest) < 32'(DRVS);
  assign is_self = 32'(dest) == 32'(last_q);

  always_comb begin
    tgt  = '0;
    drop = 1'b0;
    if (dest == BCAST_ID)       tgt  = ~self_oh;
    else if (dest_ok && !is_self) tgt = dest_oh;
    else                        drop = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LW'(DRVS - 1);
      grant_q <= '0;
      pkt_q   <= '0;
      dpush_q <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      pop_q  <= '0;
      push_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (pick_vld) begin
          last_q  <= pick_idx;
          grant_q <= ID_W'(pick_idx);
          state_q <= POP;
        end
        POP: begin
          if (pndng[last_q]) begin
            pop_q   <= self_oh;
            pkt_q   <= slice[last_q];
            state_q <= PUSH;
          end else begin
            state_q <= IDLE;
          end
        end
        PUSH: begin
          push_q  <= tgt;
          err_q   <= drop;
          if (!drop) dpush_q <= pkt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign grant_id = grant_q;
  assign err_drop = err_q;
  assign busy     = (state_q != IDLE);

endmodule
